turn_sched_ctrl: RTL and testbench
==================================

Name: turn_sched_ctrl

Overview:
- Round-robin turn scheduler for the game logic.
- Takes the one-cycle time-base strobe and sequences players through timed turns.
- Counts each turn down from a fixed budget, accepts a move only from the current player, and forces a timeout when the budget expires.
- Tracks rounds to game end; downstream game logic and display read its outputs.

Parameters:
- N_PLAYERS, 4, number of players, legal 2..8; player ids 0..N_PLAYERS-1.
- TURN_TICKS, 9, time units per turn, legal 1..15.
- MAX_ROUNDS, 8, full rounds per game, legal 1..15.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start/restart pulse; honoured only in IDLE or OVER.
- i_tick  in  1  one-cycle time-unit strobe from the time base.
- i_pause  in  1  level; while high, ticks and moves are ignored.
- i_move_valid  in  1  move commit strobe.
- i_move_id  in  3  id of the committing player.
- o_player  out  3  current player id.
- o_time_left  out  4  remaining time units in the current turn.
- o_turn_active  out  1  high only in TURN state.
- o_move_ack  out  1  one-cycle pulse: move accepted.
- o_timeout  out  1  one-cycle pulse: turn expired.
- o_round  out  4  current round index; equals MAX_ROUNDS in OVER.
- o_game_over  out  1  high only in OVER state.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-turn) forces:
  - state IDLE
  - o_player=0, o_time_left=0, o_round=0
  - all pulses and flags 0
- States: IDLE, TURN, SWITCH, OVER.
- IDLE:
  - On i_start go to TURN; load o_player=0, o_round=0, o_time_left=TURN_TICKS.
  - All other inputs are ignored.
- TURN:
  - A move is accepted when i_move_valid=1, i_move_id==o_player and i_pause=0.
  - A mismatched i_move_id is silently ignored.
  - Accepted move in cycle k: cycle k+1 is SWITCH, o_move_ack=1, o_turn_active=0; o_time_left holds its value.
  - i_tick with i_pause=0 and o_time_left>1: decrement o_time_left by 1.
  - i_tick with i_pause=0 and o_time_left==1: o_time_left=0; next cycle is SWITCH with o_timeout=1.
  - Accepted move and expiring tick in the same cycle: the move wins; o_move_ack=1, o_timeout=0.
  - i_start in TURN is ignored.
- SWITCH (exactly one cycle):
  - o_player advances by 1; N_PLAYERS-1 wraps to 0.
  - On wrap, o_round increments.
  - If the incremented round equals MAX_ROUNDS, go to OVER.
  - Otherwise go to TURN with o_time_left=TURN_TICKS.
  - The next player's TURN therefore begins at cycle k+2 after the move or expiring tick in cycle k.
  - Inputs in SWITCH are ignored; the pulses drop after this cycle.
- OVER:
  - o_game_over=1; o_player=0, o_round=MAX_ROUNDS and o_time_left=0 are held.
  - i_start behaves as in IDLE (full restart).
  - Ticks and moves are ignored.
- Pause:
  - Pausing freezes o_time_left indefinitely; no drift on release.
  - Ticks arriving while paused are discarded, not queued.
- Arithmetic:
  - o_time_left is never below 0 and never above TURN_TICKS.
  - o_round is never above MAX_ROUNDS.
  - Unused o_player encodings never occur.

Test Plan:
- Reset, i_start, then 9 ticks with no move → o_time_left goes 9..1,0; o_timeout pulses 1 cycle; TURN resumes with o_player=1, o_time_left=9.
- In player 0's turn after 3 ticks (o_time_left=6), i_move_valid with id 0 → o_move_ack at k+1; at k+2 o_player=1, o_time_left=9, o_turn_active=1. Id 2 presented instead → no ack, countdown continues.
- Hold i_pause for 5 ticks mid-turn at o_time_left=4 → value stays 4 and moves are ignored; after release the next tick gives 3.
- At o_time_left=1, valid move and tick in the same cycle → o_move_ack=1, o_timeout=0.
- Play 32 turns by immediate moves (4 players × 8 rounds) → o_round steps 0..7; after player 3's last move: OVER, o_game_over=1, o_round=8. Then i_start → TURN with o_player=0, o_round=0.
- Assert i_rst_n low mid-turn (o_player=2, o_time_left=5) → all outputs immediately 0 and state IDLE; ticks are ignored until i_start.

Source files
------------

// File: rtl/turn_sched_ctrl.sv
// Round-robin turn scheduler: timed turns per player, move acceptance,
// timeout on budget expiry and round counting to game end.
module turn_sched_ctrl #(
    parameter int unsigned N_PLAYERS  = 4,
    parameter int unsigned TURN_TICKS = 9,
    parameter int unsigned MAX_ROUNDS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_tick,
    input  logic       i_pause,
    input  logic       i_move_valid,
    input  logic [2:0] i_move_id,
    output logic [2:0] o_player,
    output logic [3:0] o_time_left,
    output logic       o_turn_active,
    output logic       o_move_ack,
    output logic       o_timeout,
    output logic [3:0] o_round,
    output logic       o_game_over
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TURN,
        S_SWITCH,
        S_OVER
    } state_t;

    localparam logic [2:0] LAST_PLAYER = 3'(N_PLAYERS - 1);
    localparam logic [3:0] TICKS_INIT  = 4'(TURN_TICKS);
    localparam logic [3:0] ROUND_END   = 4'(MAX_ROUNDS);

    state_t     r_state;
    logic [2:0] r_player;
    logic [3:0] r_time_left;
    logic [3:0] r_round;
    logic       r_turn_active;
    logic       r_move_ack;
    logic       r_timeout;
    logic       r_game_over;

    logic       w_move_ok;
    logic       w_tick_ok;
    logic       w_wrap;
    logic [3:0] w_round_next;

    // Pause masks both moves and ticks; paused ticks are simply dropped.
    assign w_move_ok    = (r_state == S_TURN) && i_move_valid && !i_pause &&
                          (i_move_id == r_player);
    assign w_tick_ok    = (r_state == S_TURN) && i_tick && !i_pause;
    assign w_wrap       = (r_player == LAST_PLAYER);
    assign w_round_next = r_round + 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_player      <= '0;
            r_time_left   <= '0;
            r_round       <= '0;
            r_turn_active <= 1'b0;
            r_move_ack    <= 1'b0;
            r_timeout     <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_move_ack <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (i_start) begin
                        r_state       <= S_TURN;
                        r_player      <= '0;
                        r_round       <= '0;
                        r_time_left   <= TICKS_INIT;
                        r_turn_active <= 1'b1;
                        r_game_over   <= 1'b0;
                    end
                end
                S_TURN: begin
                    // A move in the same cycle as the expiring tick takes priority.
                    if (w_move_ok) begin
                        r_state       <= S_SWITCH;
                        r_move_ack    <= 1'b1;
                        r_turn_active <= 1'b0;
                    end else if (w_tick_ok) begin
                        if (r_time_left > 4'd1) begin
                            r_time_left <= r_time_left - 4'd1;
                        end else begin
                            r_time_left   <= '0;
                            r_state       <= S_SWITCH;
                            r_timeout     <= 1'b1;
                            r_turn_active <= 1'b0;
                        end
                    end
                end
                S_SWITCH: begin
                    if (w_wrap && (w_round_next == ROUND_END)) begin
                        r_state       <= S_OVER;
                        r_player      <= '0;
                        r_round       <= ROUND_END;
                        r_time_left   <= '0;
                        r_game_over   <= 1'b1;
                        r_turn_active <= 1'b0;
                    end else begin
                        r_state       <= S_TURN;
                        r_player      <= w_wrap ? 3'd0 : r_player + 3'd1;
                        r_round       <= w_wrap ? w_round_next : r_round;
                        r_time_left   <= TICKS_INIT;
                        r_turn_active <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_player      = r_player;
    assign o_time_left   = r_time_left;
    assign o_turn_active = r_turn_active;
    assign o_move_ack    = r_move_ack;
    assign o_timeout     = r_timeout;
    assign o_round       = r_round;
    assign o_game_over   = r_game_over;

endmodule

// File: tb/tb_turn_sched_ctrl.sv
// Bench for turn_sched_ctrl: directed stimulus with a pulse-event scoreboard.
module tb_turn_sched_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_tick;
    logic       i_pause;
    logic       i_move_valid;
    logic [2:0] i_move_id;
    logic [2:0] o_player;
    logic [3:0] o_time_left;
    logic       o_turn_active;
    logic       o_move_ack;
    logic       o_timeout;
    logic [3:0] o_round;
    logic       o_game_over;

    typedef struct packed {
        logic       ack;
        logic       tmo;
        logic [2:0] player;
        logic [3:0] tl;
        logic [3:0] round;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_err    = 0;

    turn_sched_ctrl #(
        .N_PLAYERS (4),
        .TURN_TICKS(9),
        .MAX_ROUNDS(8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_tick       (i_tick),
        .i_pause      (i_pause),
        .i_move_valid (i_move_valid),
        .i_move_id    (i_move_id),
        .o_player     (o_player),
        .o_time_left  (o_time_left),
        .o_turn_active(o_turn_active),
        .o_move_ack   (o_move_ack),
        .o_timeout    (o_timeout),
        .o_round      (o_round),
        .o_game_over  (o_game_over)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic tick, input logic mv, input logic [2:0] id,
                         input logic pause, input logic start);
        i_tick       = tick;
        i_move_valid = mv;
        i_move_id    = id;
        i_pause      = pause;
        i_start      = start;
        @(posedge i_clk);
        #1;
        i_tick       = 1'b0;
        i_move_valid = 1'b0;
        i_move_id    = 3'd0;
        i_pause      = 1'b0;
        i_start      = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic push_ev(input logic ack, input int p, input int tl, input int r);
        exp_q.push_back({ack, ~ack, 3'(p), 4'(tl), 4'(r)});
    endtask

    // Monitor: every pulse seen must match the head of the expected-event queue.
    always @(negedge i_clk) begin
        if (o_move_ack || o_timeout) begin
            ev_t act;
            ev_t e;
            act = {o_move_ack, o_timeout, o_player, o_time_left, o_round};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: got %h expected none", act);
            end else begin
                e = exp_q.pop_front();
                if (act != e) begin
                    n_err++;
                    $display("FAIL pulse_event: got %h expected %h", act, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0; i_tick = 1'b0; i_pause = 1'b0;
        i_move_valid = 1'b0; i_move_id = 3'd0;
        @(posedge i_clk); @(posedge i_clk); #1;
        chk("rst_player", o_player, 0);
        chk("rst_tl", o_time_left, 0);
        chk("rst_round", o_round, 0);
        chk("rst_flags", {o_turn_active, o_move_ack, o_timeout, o_game_over}, 0);
        i_rst_n = 1'b1;

        // Idle ignores ticks and moves
        drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        chk("idle_tl", o_time_left, 0);
        chk("idle_active", o_turn_active, 0);

        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("start_active", o_turn_active, 1);
        chk("start_tl", o_time_left, 9);
        chk("start_player", o_player, 0);

        // Full countdown to timeout
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) push_ev(1'b0, 0, 0, 0);
            drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
            chk("count_tl", o_time_left, 9 - i);
        end
        chk("tmo_active", o_turn_active, 0);
        idle();
        chk("tmo_next_player", o_player, 1);
        chk("tmo_next_tl", o_time_left, 9);
        chk("tmo_next_active", o_turn_active, 1);

        // Player 1: wrong id and start ignored, then correct move
        repeat (3) drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("p1_tl6", o_time_left, 6);
        drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
        chk("wrong_id_active", o_turn_active, 1);
        chk("wrong_id_tl", o_time_left, 6);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("after_wrong_tl", o_time_left, 5);
        push_ev(1'b1, 1, 5, 0);
        drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        chk("ack_active", o_turn_active, 0);
        chk("ack_tl_hold", o_time_left, 5);
        idle();
        chk("p2_player", o_player, 2);
        chk("p2_tl", o_time_left, 9);

        // Pause freezes countdown and blocks moves
        repeat (5) drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("p2_tl4", o_time_left, 4);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
            chk("pause_tl", o_time_left, 4);
        end
        chk("pause_active", o_turn_active, 1);
        idle();
        chk("release_tl", o_time_left, 4);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("release_tick_tl", o_time_left, 3);

        // Move and expiring tick together: move wins
        repeat (2) drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("p2_tl1", o_time_left, 1);
        push_ev(1'b1, 2, 1, 0);
        drive(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        chk("race_tl", o_time_left, 1);
        idle();
        chk("p3_player", o_player, 3);

        push_ev(1'b1, 3, 9, 0);
        drive(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        idle();

        // Remaining rounds by immediate moves
        for (int r = 1; r <= 7; r++) begin
            for (int p = 0; p < 4; p++) begin
                chk("loop_player", o_player, p);
                chk("loop_round", o_round, r);
                chk("loop_tl", o_time_left, 9);
                push_ev(1'b1, p, 9, r);
                drive(1'b0, 1'b1, 3'(p), 1'b0, 1'b0);
                idle();
            end
        end
        chk("over_flag", o_game_over, 1);
        chk("over_round", o_round, 8);
        chk("over_player", o_player, 0);
        chk("over_tl", o_time_left, 0);
        chk("over_active", o_turn_active, 0);
        drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        chk("over_hold", {o_game_over, o_round}, {1'b1, 4'd8});

        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("restart_flags", {o_turn_active, o_game_over}, 2);
        chk("restart_round", o_round, 0);
        chk("restart_tl", o_time_left, 9);

        // Asynchronous reset mid-turn
        push_ev(1'b1, 0, 9, 0);
        drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        idle();
        push_ev(1'b1, 1, 9, 0);
        drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        idle();
        repeat (4) drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("pre_rst_state", {o_player, o_time_left}, {3'd2, 4'd5});
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {o_player, o_time_left, o_round, o_turn_active,
                               o_move_ack, o_timeout, o_game_over}, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("post_rst_tl", o_time_left, 0);
        chk("post_rst_active", o_turn_active, 0);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("post_rst_start", {o_turn_active, o_player, o_time_left}, {1'b1, 3'd0, 4'd9});

        repeat (2) idle();
        chk("events_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
